// File: rtl/vc_sched_pkg.sv
// Shared types and constants for the virtual-channel output scheduler.
//
// Contents:
//   FLIT_WIDTH      - default flit width; the top two bits carry the flit type
//   FLIT_TYPE_MSB/LSB - bit positions of the type field inside a flit
//   flit_type_t     - HEAD / BODY / TAIL / HEAD_TAIL encodings
//   sched_state_t   - scheduler lock FSM states (idle / locked)
//   is_pkt_cont()   - true for flit types that continue an open packet
package vc_sched_pkg;

  localparam int unsigned FLIT_WIDTH    = 34;
  localparam int unsigned FLIT_TYPE_MSB = 33;
  localparam int unsigned FLIT_TYPE_LSB = 32;

  typedef enum logic [1:0] {
    FlitHead     = 2'b00,
    FlitBody     = 2'b01,
    FlitHeadTail = 2'b10,
    FlitTail     = 2'b11
  } flit_type_t;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } sched_state_t;

  // BODY and TAIL are only legal inside a packet opened by a HEAD.
  function automatic logic is_pkt_cont(flit_type_t t);
    return (t == FlitBody) || (t == FlitTail);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Masked round-robin priority encoder.
//
// Grants the first asserted request at or after ptr_i, searching upward and
// wrapping modulo NumReq (NumReq must be a power of two).
//
// Ports:
//   req_i   - request vector
//   ptr_i   - highest-priority index for this cycle
//   grant_o - one-hot grant (all zero when no request)
//   idx_o   - index of the granted request (zero when no request)
//   any_o   - at least one request present
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      // Truncating add gives the modulo wrap for free.
      cand = ptr_i + IdxW'(i);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/vc_out_scheduler.sv
// Output-link scheduler for N_VIRT_CHN virtual-channel buffers.
//
// Picks one VC per cycle with a round-robin arbiter and forwards its flit to
// the link with zero-cycle latency. Under backpressure the current grant is
// held as long as the granted VC keeps its valid asserted.
//
// Build option:
//   VC_SCHED_WORMHOLE_LOCK_EN - when defined, a HEAD flit locks the link to its
//     VC until the matching TAIL, and packet-framing violations set the sticky
//     proto_err_o flag. When undefined, flits interleave per cycle and
//     proto_err_o is tied low.
//
// Ports:
//   clk         - clock, rising edge
//   arst        - asynchronous active-low reset
//   vc_valid_i  - per-VC flit valid
//   vc_flit_i   - per-VC flit, VC k at [k*FLIT_WIDTH +: FLIT_WIDTH]
//   vc_ready_o  - per-VC pop strobe (one-hot or zero)
//   fdata_o     - granted flit, zero when valid_o is low
//   valid_o     - link valid
//   vc_id_o     - VC index of fdata_o
//   ready_i     - link ready
//   proto_err_o - sticky protocol-error flag
module vc_out_scheduler #(
  parameter int unsigned N_VIRT_CHN = 4,
  parameter int unsigned FLIT_WIDTH = vc_sched_pkg::FLIT_WIDTH,
  localparam int unsigned IdxW      = $clog2(N_VIRT_CHN)
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [N_VIRT_CHN-1:0]            vc_valid_i,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] vc_flit_i,
  output logic [N_VIRT_CHN-1:0]            vc_ready_o,
  output logic [FLIT_WIDTH-1:0]            fdata_o,
  output logic                             valid_o,
  output logic [IdxW-1:0]                  vc_id_o,
  input  logic                             ready_i,
  output logic                             proto_err_o
);

  import vc_sched_pkg::*;

  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  hold_q, hold_d;
  logic [IdxW-1:0]       hold_vc_q, hold_vc_d;

  logic [N_VIRT_CHN-1:0] elig;
  logic [N_VIRT_CHN-1:0] req;
  logic [N_VIRT_CHN-1:0] grant;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [FLIT_WIDTH-1:0] gnt_flit;
  flit_type_t            gnt_type;
  logic                  xfer;

`ifdef VC_SCHED_WORMHOLE_LOCK_EN
  sched_state_t          state_q, state_d;
  logic [IdxW-1:0]       lock_vc_q, lock_vc_d;
  logic                  err_q, err_d;
  logic [N_VIRT_CHN-1:0] lock_mask;

  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_vc_q] = 1'b1;
    elig = (state_q == StLocked) ? (vc_valid_i & lock_mask) : vc_valid_i;
  end
`else
  always_comb begin
    elig = vc_valid_i;
  end
`endif

  // A stalled grant is pinned so a newly valid higher-priority VC cannot
  // swap the flit out from under the link.
  always_comb begin
    req = elig;
    if (hold_q && elig[hold_vc_q]) begin
      req            = '0;
      req[hold_vc_q] = 1'b1;
    end
  end

  rr_arbiter #(
    .NumReq(N_VIRT_CHN)
  ) u_rr_arbiter (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  assign gnt_flit = vc_flit_i[gnt_idx*FLIT_WIDTH +: FLIT_WIDTH];
  assign gnt_type = flit_type_t'(gnt_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);

  // Outputs are combinational from vc_valid_i, so they are gated by reset too.
  always_comb begin
    valid_o    = arst & gnt_any;
    xfer       = valid_o & ready_i;
    fdata_o    = valid_o ? gnt_flit : '0;
    vc_id_o    = valid_o ? gnt_idx : '0;
    vc_ready_o = xfer ? grant : '0;
  end

  always_comb begin
    rr_ptr_d  = xfer ? (gnt_idx + IdxW'(1)) : rr_ptr_q;
    hold_d    = valid_o & ~ready_i;
    hold_vc_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rr_ptr_q  <= '0;
      hold_q    <= 1'b0;
      hold_vc_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      hold_vc_q <= hold_vc_d;
    end
  end

`ifdef VC_SCHED_WORMHOLE_LOCK_EN
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    err_d     = err_q;
    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (gnt_type == FlitHead) begin
            state_d   = StLocked;
            lock_vc_d = gnt_idx;
          end else if (is_pkt_cont(gnt_type)) begin
            err_d = 1'b1;
          end
        end
        StLocked: begin
          if (gnt_type == FlitHead) begin
            err_d = 1'b1;
          end else if ((gnt_type == FlitTail) && (gnt_idx == lock_vc_q)) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= StIdle;
      lock_vc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      err_q     <= err_d;
    end
  end

  assign proto_err_o = err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_out_scheduler.sv
// Directed bench for vc_out_scheduler (N_VIRT_CHN=4, FLIT_WIDTH=34).
// Lock-mode scenarios are compiled in when VC_SCHED_WORMHOLE_LOCK_EN is defined.
module tb_vc_out_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 34;

  logic          clk;
  logic          arst;
  logic [N-1:0]  vc_valid;
  logic [FW-1:0] flit [N];
  logic [N*FW-1:0] vc_flit;
  logic [N-1:0]  vc_ready;
  logic [FW-1:0] fdata;
  logic          valid;
  logic [1:0]    vc_id;
  logic          ready;
  logic          proto_err;

  int n_vec;
  int n_err;

  assign vc_flit = {flit[3], flit[2], flit[1], flit[0]};

  vc_out_scheduler #(
    .N_VIRT_CHN(N),
    .FLIT_WIDTH(FW)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .vc_valid_i (vc_valid),
    .vc_flit_i  (vc_flit),
    .vc_ready_o (vc_ready),
    .fdata_o    (fdata),
    .valid_o    (valid),
    .vc_id_o    (vc_id),
    .ready_i    (ready),
    .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1
  // unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    arst = 1'b0;
    tick();
    arst = 1'b1;
  endtask

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_HT   = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic [1:0] pkt_t [3];
  int         pidx  [2];
  logic [3:0] one_hot;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    pkt_t[0] = T_HEAD;
    pkt_t[1] = T_BODY;
    pkt_t[2] = T_TAIL;
    arst     = 1'b0;
    ready    = 1'b1;
    vc_valid = 4'b1111;
    for (int k = 0; k < 4; k++) flit[k] = mk(T_HT, 32'hA0 + k);

    // Reset state with all VCs requesting.
    tick();
    tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ready", 64'(vc_ready), 64'd0);
    check("rst_fdata", 64'(fdata), 64'd0);
    check("rst_vc_id", 64'(vc_id), 64'd0);
    check("rst_err", 64'(proto_err), 64'd0);

    // Round-robin sequence 0,1,2,3,0 with one transfer per cycle.
    arst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      one_hot = 4'b0001 << (i % 4);
      check("rr_valid", 64'(valid), 64'd1);
      check("rr_vc_id", 64'(vc_id), 64'(i % 4));
      check("rr_ready", 64'(vc_ready), 64'(one_hot));
      check("rr_fdata", 64'(fdata), 64'(mk(T_HT, 32'hA0 + (i % 4))));
      tick();
    end
    // rr_ptr is now 1.

    // Backpressure: VC2 alone, link stalled for 3 cycles.
    ready    = 1'b0;
    vc_valid = 4'b0100;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(valid), 64'd1);
      check("bp_vc_id", 64'(vc_id), 64'd2);
      check("bp_fdata", 64'(fdata), 64'(mk(T_HT, 32'hA2)));
      check("bp_ready", 64'(vc_ready), 64'd0);
      tick();
    end
    // Pointer must still be 1: VC1 wins over VC0.
    vc_valid = 4'b0011;
    ready    = 1'b1;
    #1;
    check("bp_ptr_kept", 64'(vc_id), 64'd1);
    tick();
    // rr_ptr is now 2.

    // Held grant: VC3 stalled, then VC2 (higher priority at ptr=2) appears.
    ready    = 1'b0;
    vc_valid = 4'b1000;
    #1;
    check("hold_first", 64'(vc_id), 64'd3);
    tick();
    vc_valid = 4'b1100;
    #1;
    check("hold_keep", 64'(vc_id), 64'd3);
    check("hold_fdata", 64'(fdata), 64'(mk(T_HT, 32'hA3)));
    ready = 1'b1;
    #1;
    check("hold_release", 64'(vc_ready), 64'b1000);
    tick();

    // Nothing valid: zero data.
    vc_valid = 4'b0000;
    #1;
    check("idle_valid", 64'(valid), 64'd0);
    check("idle_fdata", 64'(fdata), 64'd0);

`ifndef VC_SCHED_WORMHOLE_LOCK_EN
    // Two 3-flit packets interleave flit by flit.
    reset_pulse();
    pidx[0]  = 0;
    pidx[1]  = 0;
    flit[0]  = mk(pkt_t[0], 32'h100);
    flit[1]  = mk(pkt_t[0], 32'h200);
    vc_valid = 4'b0011;
    ready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("il_vc_id", 64'(vc_id), 64'(i % 2));
      check("il_fdata", 64'(fdata),
            64'(mk(pkt_t[pidx[i % 2]], 32'h100 * (i % 2 + 1) + pidx[i % 2])));
      check("il_err", 64'(proto_err), 64'd0);
      tick();
      pidx[i % 2]++;
      if (pidx[i % 2] == 3) begin
        vc_valid[i % 2] = 1'b0;
      end else begin
        flit[i % 2] = mk(pkt_t[pidx[i % 2]], 32'h100 * (i % 2 + 1) + pidx[i % 2]);
      end
    end
    #1;
    check("il_done", 64'(valid), 64'd0);
    check("il_err_end", 64'(proto_err), 64'd0);
`else
    // Wormhole lock: move pointer to 1, then VC1 sends H,B,T among VC0/VC3.
    reset_pulse();
    flit[0]  = mk(T_HT, 32'h10);
    vc_valid = 4'b0001;
    ready    = 1'b1;
    #1;
    check("lk_pre", 64'(vc_id), 64'd0);
    tick();
    flit[1]  = mk(T_HEAD, 32'h11);
    flit[3]  = mk(T_HT, 32'h13);
    vc_valid = 4'b1011;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("lk_vc_id", 64'(vc_id), 64'd1);
      tick();
      flit[1] = mk(pkt_t[(j + 1) % 3], 32'h11);
    end
    vc_valid = 4'b1001;
    #1;
    check("lk_after", 64'(vc_id), 64'd3);
    check("lk_err", 64'(proto_err), 64'd0);
    tick();

    // BODY in IDLE is forwarded and raises the sticky error.
    reset_pulse();
    flit[0]  = mk(T_BODY, 32'h20);
    vc_valid = 4'b0001;
    #1;
    check("err_fwd", 64'(valid), 64'd1);
    check("err_before", 64'(proto_err), 64'd0);
    tick();
    vc_valid = 4'b0000;
    #1;
    check("err_set", 64'(proto_err), 64'd1);
    tick();
    check("err_sticky", 64'(proto_err), 64'd1);

    // Reset while locked on VC2 drops the lock.
    reset_pulse();
    flit[2]  = mk(T_HEAD, 32'h32);
    vc_valid = 4'b0100;
    #1;
    tick();
    flit[2]  = mk(T_BODY, 32'h32);
    flit[0]  = mk(T_HEAD, 32'h30);
    vc_valid = 4'b0101;
    #1;
    check("rl_locked", 64'(vc_id), 64'd2);
    reset_pulse();
    #1;
    check("rl_vc_id", 64'(vc_id), 64'd0);
    check("rl_err", 64'(proto_err), 64'd0);
    tick();
    check("rl_err_after", 64'(proto_err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
